// File: rtl/vga_scandoubler.sv
// vga_scandoubler: captures each 15 kHz PAL line into one bank of a two-bank
// line buffer and replays the other bank twice at the full clk rate, giving
// 31 kHz video. Optional scanline dimming on the second replica, and a
// registered bypass path for native PAL monitors.
module vga_scandoubler #(
   parameter int HSYNC_LEN   = 54,
   parameter int DEFAULT_LEN = 448,
   parameter int MIN_LEN     = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pixel_en,
   input  logic       enable_scandoubler,
   input  logic       scanlines,
   input  logic [2:0] ri,
   input  logic [2:0] gi,
   input  logic [2:0] bi,
   input  logic       hsync_i,
   input  logic       vsync_i,
   output logic [2:0] ro,
   output logic [2:0] go,
   output logic [2:0] bo,
   output logic       hsync_o,
   output logic       vsync_o
);

   localparam logic [8:0] HSYNC_LEN_C   = 9'(HSYNC_LEN);
   localparam logic [9:0] DEFAULT_LEN_C = 10'(DEFAULT_LEN);
   localparam logic [9:0] MIN_LEN_C     = 10'(MIN_LEN);

   // {bank, address} -> {r,g,b}
   logic [8:0] line_mem [0:1023];

   // write side
   logic       wbank_q, wbank_d;
   logic       rbank_q, rbank_d;
   logic [9:0] waddr_q, waddr_d;
   logic [9:0] len_q, len_d;
   logic       hs_prev_q, hs_prev_d;
   logic       vs_hold_q, vs_hold_d;
   logic       restart_q, restart_d;
   logic       we_s;
   logic [9:0] wa_s;
   logic [8:0] wdata_s;

   // read side
   logic [8:0] rcnt_q, rcnt_d;
   logic       half_q, half_d;

   // read pipeline stage (aligned with the RAM output)
   logic [8:0] rdata_q, rdata_d;
   logic       hs1_q, hs1_d;
   logic       half1_q, half1_d;

   // output register
   logic [2:0] ro_q, ro_d;
   logic [2:0] go_q, go_d;
   logic [2:0] bo_q, bo_d;
   logic       hsync_o_q, hsync_o_d;
   logic       vsync_o_q, vsync_o_d;

   // Write side: store pixels, detect qualified line starts, swap banks.
   always_comb begin
      wbank_d   = wbank_q;
      rbank_d   = rbank_q;
      waddr_d   = waddr_q;
      len_d     = len_q;
      hs_prev_d = hs_prev_q;
      vs_hold_d = vs_hold_q;
      restart_d = 1'b0;
      we_s      = 1'b0;
      wa_s      = {wbank_q, waddr_q[8:0]};
      wdata_s   = {ri, gi, bi};
      if (pixel_en) begin
         hs_prev_d = hsync_i;
         if (hs_prev_q && !hsync_i && (waddr_q >= MIN_LEN_C)) begin
            // waddr saturates at 512, so it already equals min(waddr, 512)
            len_d     = waddr_q;
            rbank_d   = wbank_q;
            wbank_d   = ~wbank_q;
            waddr_d   = 10'd1;
            vs_hold_d = vsync_i;
            restart_d = 1'b1;
            we_s      = 1'b1;
            wa_s      = {~wbank_q, 9'd0};
         end else if (waddr_q < 10'd512) begin
            we_s    = 1'b1;
            waddr_d = waddr_q + 10'd1;
         end else begin
            // line too long: extra pixels are dropped
            we_s = 1'b0;
         end
      end else begin
         hs_prev_d = hs_prev_q;
      end
   end

   // Read side: free-running replay counter; restart beats the wrap.
   always_comb begin
      rcnt_d  = rcnt_q + 9'd1;
      half_d  = half_q;
      if (restart_q) begin
         rcnt_d = 9'd0;
         half_d = 1'b0;
      end else if ({1'b0, rcnt_q} >= (len_q - 10'd1)) begin
         rcnt_d = 9'd0;
         half_d = 1'b1;
      end else begin
         half_d = half_q;
      end
      rdata_d = line_mem[{rbank_q, rcnt_q}];
      hs1_d   = (rcnt_q >= HSYNC_LEN_C);
      half1_d = half_q;
   end

   // Output select: registered bypass, or blanked/dimmed replay data.
   always_comb begin
      ro_d      = 3'd0;
      go_d      = 3'd0;
      bo_d      = 3'd0;
      hsync_o_d = 1'b1;
      vsync_o_d = 1'b1;
      if (!enable_scandoubler) begin
         ro_d      = ri;
         go_d      = gi;
         bo_d      = bi;
         hsync_o_d = hsync_i;
         vsync_o_d = vsync_i;
      end else begin
         hsync_o_d = hs1_q;
         vsync_o_d = vs_hold_q;
         if (!hs1_q) begin
            ro_d = 3'd0;
            go_d = 3'd0;
            bo_d = 3'd0;
         end else if (scanlines && half1_q) begin
            ro_d = {1'b0, rdata_q[8:7]};
            go_d = {1'b0, rdata_q[5:4]};
            bo_d = {1'b0, rdata_q[2:1]};
         end else begin
            ro_d = rdata_q[8:6];
            go_d = rdata_q[5:3];
            bo_d = rdata_q[2:0];
         end
      end
   end

   // Line buffer write port (contents are not reset).
   always_ff @(posedge clk) begin
      if (we_s) begin
         line_mem[wa_s] <= wdata_s;
      end
   end

   // State, read pipeline and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wbank_q   <= 1'b0;
         rbank_q   <= 1'b1;
         waddr_q   <= 10'd0;
         len_q     <= DEFAULT_LEN_C;
         hs_prev_q <= 1'b1;
         vs_hold_q <= 1'b1;
         restart_q <= 1'b0;
         rcnt_q    <= 9'd0;
         half_q    <= 1'b0;
         rdata_q   <= 9'd0;
         hs1_q     <= 1'b1;
         half1_q   <= 1'b0;
         ro_q      <= 3'd0;
         go_q      <= 3'd0;
         bo_q      <= 3'd0;
         hsync_o_q <= 1'b1;
         vsync_o_q <= 1'b1;
      end else begin
         wbank_q   <= wbank_d;
         rbank_q   <= rbank_d;
         waddr_q   <= waddr_d;
         len_q     <= len_d;
         hs_prev_q <= hs_prev_d;
         vs_hold_q <= vs_hold_d;
         restart_q <= restart_d;
         rcnt_q    <= rcnt_d;
         half_q    <= half_d;
         rdata_q   <= rdata_d;
         hs1_q     <= hs1_d;
         half1_q   <= half1_d;
         ro_q      <= ro_d;
         go_q      <= go_d;
         bo_q      <= bo_d;
         hsync_o_q <= hsync_o_d;
         vsync_o_q <= vsync_o_d;
      end
   end

   assign ro      = ro_q;
   assign go      = go_q;
   assign bo      = bo_q;
   assign hsync_o = hsync_o_q;
   assign vsync_o = vsync_o_q;

endmodule

// File: tb/tb_vga_scandoubler.sv
// Testbench for vga_scandoubler: random and directed PAL lines, compared
// every clk against a line-level reference model (captured line, replay
// position measured in clks since restart, two-clk output latency).
module tb_vga_scandoubler;

   logic       clk = 1'b0;
   logic       rst;
   logic       pixel_en;
   logic       enable_scandoubler;
   logic       scanlines;
   logic [2:0] ri, gi, bi;
   logic       hsync_i, vsync_i;
   logic [2:0] ro, go, bo;
   logic       hsync_o, vsync_o;

   int n_vec = 0;
   int n_err = 0;

   vga_scandoubler dut (
      .clk                (clk),
      .rst                (rst),
      .pixel_en           (pixel_en),
      .enable_scandoubler (enable_scandoubler),
      .scanlines          (scanlines),
      .ri                 (ri),
      .gi                 (gi),
      .bi                 (bi),
      .hsync_i            (hsync_i),
      .vsync_i            (vsync_i),
      .ro                 (ro),
      .go                 (go),
      .bo                 (bo),
      .hsync_o            (hsync_o),
      .vsync_o            (vsync_o)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [8:0] cap    [512];
   logic [8:0] rep    [512];
   bit         rep_ok [512];
   int         m_cnt;      // strobes since last accepted line start
   int         m_len;      // length of the line being replayed
   int         m_tl_len;   // length governing the current replay timeline
   int         m_pos;      // clks since replay (re)started
   bit         m_restart;
   bit         m_prev_hs;
   bit         m_vs_hold;
   logic [8:0] s1_pix;
   bit         s1_ok, s1_vis, s1_half;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [8:0] dim(input logic [8:0] p);
      return {1'b0, p[8:7], 1'b0, p[5:4], 1'b0, p[2:1]};
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_len = 448; m_tl_len = 448; m_pos = 0;
      m_restart = 1'b0; m_prev_hs = 1'b1; m_vs_hold = 1'b1;
      for (int i = 0; i < 512; i++) rep_ok[i] = 1'b0;
      s1_pix = 9'd0; s1_ok = 1'b1; s1_vis = 1'b1; s1_half = 1'b0;
   endtask

   // One clk: predict what this edge produces, advance the model, compare.
   task automatic tick();
      logic [8:0] e_rgb;
      bit         e_hs, e_vs, e_ok;
      int         rc;
      if (rst) begin
         e_rgb = 9'd0; e_hs = 1'b1; e_vs = 1'b1; e_ok = 1'b1;
      end else if (!enable_scandoubler) begin
         e_rgb = {ri, gi, bi}; e_hs = hsync_i; e_vs = vsync_i; e_ok = 1'b1;
      end else begin
         e_hs = s1_vis;
         e_vs = m_vs_hold;
         e_ok = !s1_vis || s1_ok;
         if (!s1_vis) e_rgb = 9'd0;
         else if (scanlines && s1_half) e_rgb = dim(s1_pix);
         else e_rgb = s1_pix;
      end
      if (rst) begin
         model_reset();
      end else begin
         rc      = m_pos % m_tl_len;
         s1_pix  = rep[rc];
         s1_ok   = rep_ok[rc];
         s1_vis  = (rc >= 54);
         s1_half = (m_pos >= m_tl_len);
         if (m_restart) begin
            m_pos = 0; m_tl_len = m_len;
         end else begin
            m_pos++;
         end
         m_restart = 1'b0;
         if (pixel_en) begin
            if (m_prev_hs && !hsync_i && m_cnt >= 64) begin
               m_len = (m_cnt > 512) ? 512 : m_cnt;
               for (int i = 0; i < 512; i++) begin
                  rep[i]    = cap[i];
                  rep_ok[i] = (i < m_len);
               end
               cap[0]    = {ri, gi, bi};
               m_cnt     = 1;
               m_vs_hold = vsync_i;
               m_restart = 1'b1;
            end else begin
               if (m_cnt < 512) cap[m_cnt] = {ri, gi, bi};
               m_cnt++;
            end
            m_prev_hs = hsync_i;
         end
      end
      @(posedge clk);
      #1;
      chk("sync", 16'({hsync_o, vsync_o}), 16'({e_hs, e_vs}));
      if (e_ok) chk("rgb", 16'({ro, go, bo}), 16'(e_rgb));
   endtask

   // kind: 0 = ramp, 1 = random, 2 = white. glitch adds a short false edge.
   task automatic drive_line(input int n, input int kind, input bit glitch);
      logic vs;
      logic [8:0] pix;
      vs = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
         case (kind)
            0:       pix = 9'(i);
            1:       pix = 9'($urandom);
            default: pix = 9'h1FF;
         endcase
         {ri, gi, bi} = pix;
         if (glitch) hsync_i = !((i < 5) || (i >= 10 && i < 32));
         else        hsync_i = !(i < 32);
         vsync_i  = vs;
         pixel_en = 1'b1;
         tick();
         {ri, gi, bi} = 9'($urandom);
         pixel_en = 1'b0;
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; pixel_en = 1'b0; enable_scandoubler = 1'b1; scanlines = 1'b0;
      ri = 3'd0; gi = 3'd0; bi = 3'd0; hsync_i = 1'b1; vsync_i = 1'b1;
      model_reset();

      // reset with random inputs, then the first clk after release
      for (int i = 0; i < 3; i++) begin
         {ri, gi, bi, hsync_i, vsync_i, pixel_en} = 14'($urandom);
         tick();
      end
      rst = 1'b0;
      pixel_en = 1'b0;
      tick();

      // bypass: directed colour, then random
      enable_scandoubler = 1'b0;
      ri = 3'd5; gi = 3'd2; bi = 3'd7; hsync_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pixel_en = ~pixel_en;
         tick();
      end
      for (int i = 0; i < 40; i++) begin
         {ri, gi, bi, hsync_i, vsync_i} = 11'($urandom);
         pixel_en = ~pixel_en;
         tick();
      end
      hsync_i = 1'b1; pixel_en = 1'b1;
      tick();

      // doubling: ramp line then replay
      enable_scandoubler = 1'b1;
      drive_line(100, 1, 1'b0);
      drive_line(448, 0, 1'b0);
      drive_line(448, 1, 1'b0);
      drive_line(448, 1, 1'b0);

      // scanlines on white, then off
      scanlines = 1'b1;
      drive_line(448, 2, 1'b0);
      drive_line(448, 2, 1'b0);
      drive_line(448, 1, 1'b0);
      scanlines = 1'b0;
      drive_line(448, 2, 1'b0);
      drive_line(448, 1, 1'b0);

      // overlong line
      drive_line(600, 1, 1'b0);
      drive_line(448, 1, 1'b0);

      // glitch edge shortly after a valid edge
      drive_line(448, 1, 1'b1);
      drive_line(448, 1, 1'b0);

      // mid-operation reset
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      scanlines = 1'b1;
      drive_line(448, 1, 1'b0);
      drive_line(448, 1, 1'b0);

      // mode switching
      enable_scandoubler = 1'b0;
      drive_line(200, 1, 1'b0);
      enable_scandoubler = 1'b1;
      drive_line(448, 1, 1'b0);
      drive_line(448, 1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
